// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone SRAM arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } arb_state_t;

    localparam logic MASTER_M0 = 1'b0;
    localparam logic MASTER_M1 = 1'b1;

    localparam int unsigned SEL_WIDTH = 4;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the master other than `last` wins.
module wb_arb_rr_pick
    import wb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == MASTER_M1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/wishbone_sram_arbiter.sv
// Two-master Wishbone arbiter in front of a single-port SRAM slave; grant held for the whole CYC.
// Optional bus watchdog with per-master error pulses is enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_sram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_M0_CYC,
    input  logic                  i_M0_STB,
    input  logic                  i_M0_WE,
    input  logic [SEL_WIDTH-1:0]  i_M0_SEL,
    input  logic [ADDR_WIDTH-1:0] i_M0_ADDR,
    input  logic [DATA_WIDTH-1:0] i_M0_DATA,
    output logic [DATA_WIDTH-1:0] o_M0_DATA,
    output logic                  o_M0_ACK,
    input  logic                  i_M1_CYC,
    input  logic                  i_M1_STB,
    input  logic                  i_M1_WE,
    input  logic [SEL_WIDTH-1:0]  i_M1_SEL,
    input  logic [ADDR_WIDTH-1:0] i_M1_ADDR,
    input  logic [DATA_WIDTH-1:0] i_M1_DATA,
    output logic [DATA_WIDTH-1:0] o_M1_DATA,
    output logic                  o_M1_ACK,
    output logic                  o_S_CYC,
    output logic                  o_S_STB,
    output logic                  o_S_WE,
    output logic [SEL_WIDTH-1:0]  o_S_SEL,
    output logic [ADDR_WIDTH-1:0] o_S_ADDR,
    output logic [DATA_WIDTH-1:0] o_S_DATA,
    input  logic [DATA_WIDTH-1:0] i_S_DATA,
    input  logic                  i_S_ACK,
    output logic [1:0]            o_GNT
`ifdef WB_ARB_TIMEOUT_EN
    ,
    output logic                  o_M0_ERR,
    output logic                  o_M1_ERR
`endif
);

    arb_state_t state;
    logic       last;
    logic [1:0] pick;
    logic       timeout;
    logic       grant_drop;

    wb_arb_rr_pick u_pick (
        .req  ({i_M1_CYC, i_M0_CYC}),
        .last (last),
        .gnt  (pick)
    );

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wd_cnt;

    assign timeout  = (state != IDLE) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_M0_ERR = timeout && (state == GNT_M0);
    assign o_M1_ERR = timeout && (state == GNT_M1);

    // Watchdog counts stalled strobe cycles; any forwarded ack or ownership change restarts it.
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            wd_cnt <= '0;
        end else if ((state == IDLE) || grant_drop || o_M0_ACK || o_M1_ACK) begin
            wd_cnt <= '0;
        end else if (o_S_STB && !i_S_ACK) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    assign grant_drop = ((state == GNT_M0) && (!i_M0_CYC || timeout)) ||
                        ((state == GNT_M1) && (!i_M1_CYC || timeout));

    // Ownership hands straight over to a waiting master; otherwise fall back to IDLE.
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state <= IDLE;
            last  <= MASTER_M1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick[0]) begin
                        state <= GNT_M0;
                    end else if (pick[1]) begin
                        state <= GNT_M1;
                    end
                end
                GNT_M0: begin
                    if (grant_drop) begin
                        last  <= MASTER_M0;
                        state <= i_M1_CYC ? GNT_M1 : IDLE;
                    end
                end
                GNT_M1: begin
                    if (grant_drop) begin
                        last  <= MASTER_M1;
                        state <= i_M0_CYC ? GNT_M0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus steering from the registered owner; acks are dropped while reset is applied.
    always_comb begin
        o_S_CYC   = 1'b0;
        o_S_STB   = 1'b0;
        o_S_WE    = 1'b0;
        o_S_SEL   = '0;
        o_S_ADDR  = '0;
        o_S_DATA  = '0;
        o_M0_ACK  = 1'b0;
        o_M0_DATA = '0;
        o_M1_ACK  = 1'b0;
        o_M1_DATA = '0;
        unique case (state)
            GNT_M0: begin
                o_S_CYC   = i_M0_CYC;
                o_S_STB   = i_M0_STB && !timeout;
                o_S_WE    = i_M0_WE;
                o_S_SEL   = i_M0_SEL;
                o_S_ADDR  = i_M0_ADDR;
                o_S_DATA  = i_M0_DATA;
                o_M0_ACK  = i_S_ACK && i_RST && !timeout;
                o_M0_DATA = i_S_DATA;
            end
            GNT_M1: begin
                o_S_CYC   = i_M1_CYC;
                o_S_STB   = i_M1_STB && !timeout;
                o_S_WE    = i_M1_WE;
                o_S_SEL   = i_M1_SEL;
                o_S_ADDR  = i_M1_ADDR;
                o_S_DATA  = i_M1_DATA;
                o_M1_ACK  = i_S_ACK && i_RST && !timeout;
                o_M1_DATA = i_S_DATA;
            end
            default: begin
            end
        endcase
    end

    assign o_GNT = {state == GNT_M1, state == GNT_M0};

endmodule

// File: tb/tb_wishbone_sram_arbiter.sv
// Scoreboard bench for wishbone_sram_arbiter: bench-side SRAM slave, reference memory, routing monitor.
module tb_wishbone_sram_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          m_cyc [2];
    logic          m_stb [2];
    logic          m_we  [2];
    logic [3:0]    m_sel [2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_wdat[2];

    logic [DW-1:0] m0_rdat, m1_rdat;
    logic          m0_ack, m1_ack;
    logic          s_cyc, s_stb, s_we;
    logic [3:0]    s_sel;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdat;
    logic [1:0]    gnt;
    logic          s_ack_model, force_ack;
    logic [DW-1:0] s_rdat;
    wire           s_ack = s_ack_model | force_ack;
`ifdef WB_ARB_TIMEOUT_EN
    logic          m0_err, m1_err;
`endif

    wishbone_sram_arbiter dut (
        .i_CLK     (clk),
        .i_RST     (rst_n),
        .i_M0_CYC  (m_cyc[0]),
        .i_M0_STB  (m_stb[0]),
        .i_M0_WE   (m_we[0]),
        .i_M0_SEL  (m_sel[0]),
        .i_M0_ADDR (m_addr[0]),
        .i_M0_DATA (m_wdat[0]),
        .o_M0_DATA (m0_rdat),
        .o_M0_ACK  (m0_ack),
        .i_M1_CYC  (m_cyc[1]),
        .i_M1_STB  (m_stb[1]),
        .i_M1_WE   (m_we[1]),
        .i_M1_SEL  (m_sel[1]),
        .i_M1_ADDR (m_addr[1]),
        .i_M1_DATA (m_wdat[1]),
        .o_M1_DATA (m1_rdat),
        .o_M1_ACK  (m1_ack),
        .o_S_CYC   (s_cyc),
        .o_S_STB   (s_stb),
        .o_S_WE    (s_we),
        .o_S_SEL   (s_sel),
        .o_S_ADDR  (s_addr),
        .o_S_DATA  (s_wdat),
        .i_S_DATA  (s_rdat),
        .i_S_ACK   (s_ack),
        .o_GNT     (gnt)
`ifdef WB_ARB_TIMEOUT_EN
        ,
        .o_M0_ERR  (m0_err),
        .o_M1_ERR  (m1_err)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] slave_mem[64];
    logic [31:0] ref_mem[64];
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int          issued [2];
    int          ack_cnt[2];

    bit          alt_phase, burst_phase, slave_stall;
    logic [1:0]  prev_gnt, last_new;
    int          n_grants, m0_ack_in_burst;
    int unsigned lat, lat_max, wcnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-master reference: expected response captured when the beat is issued.
    task automatic issue(input int m, input bit we, input logic [3:0] sel,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic [5:0]  idx;
        logic [32:0] exp;
        idx = addr[7:2];
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
            exp = {1'b1, data};
        end else begin
            exp = {1'b0, ref_mem[idx]};
        end
        if (m == 0) q0.push_back(exp); else q1.push_back(exp);
        issued[m]++;
        m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
        m_sel[m] = sel;  m_addr[m] = addr; m_wdat[m] = data;
    endtask

    function automatic logic get_ack(input int m);
        return (m == 0) ? m0_ack : m1_ack;
    endfunction

    // Called at posedge+1; holds CYC across all beats, drops it after the last ack.
    task automatic master_burst(input int m, input int beats);
        logic [31:0] hi, dat, rnd;
        logic [5:0]  idx;
        bit          got;
        for (int b = 0; b < beats; b++) begin
            hi  = $urandom;
            dat = $urandom;
            rnd = $urandom;
            idx = (m == 0) ? 6'(rnd % 16) : 6'(16 + rnd % 16);
            issue(m, rnd[8], rnd[15:12], {hi[31:8], idx, 2'b00}, dat);
            got = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (get_ack(m)) begin
                    got = 1'b1;
                    break;
                end
            end
            check($sformatf("ack_seen_m%0d", m), 64'(got), 64'd1);
            @(posedge clk); #1;
        end
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic [1:0] want);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (gnt == want) begin
                got = 1'b1;
                break;
            end
        end
        check("wait_gnt", 64'(got), 64'd1);
    endtask

    // SRAM slave model: requests sampled mid-cycle, single-cycle ack after random latency.
    logic          smp_req, smp_we, smp_rst;
    logic [3:0]    smp_sel;
    logic [AW-1:0] smp_addr;
    logic [DW-1:0] smp_wdat;

    always @(negedge clk) begin
        smp_req  = s_cyc && s_stb;
        smp_we   = s_we;
        smp_sel  = s_sel;
        smp_addr = s_addr;
        smp_wdat = s_wdat;
        smp_rst  = rst_n;
    end

    initial begin
        logic [5:0] idx;
        s_ack_model = 1'b0;
        s_rdat      = '0;
        wcnt        = 0;
        forever begin
            @(posedge clk); #1;
            idx    = smp_addr[7:2];
            s_rdat = $urandom;
            if (!smp_rst || slave_stall) begin
                s_ack_model = 1'b0;
                wcnt        = 0;
            end else if (s_ack_model) begin
                s_ack_model = 1'b0;
            end else if (smp_req) begin
                if (wcnt >= lat) begin
                    s_ack_model = 1'b1;
                    wcnt        = 0;
                    lat         = $urandom_range(lat_max, 0);
                    if (smp_we) begin
                        for (int b = 0; b < 4; b++)
                            if (smp_sel[b]) slave_mem[idx][8*b +: 8] = smp_wdat[8*b +: 8];
                    end else begin
                        s_rdat = slave_mem[idx];
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: routing rules every cycle, scoreboard pop on every master ack.
    always @(negedge clk) begin
        logic        ok, stb_ok;
        logic [32:0] e;
        if (rst_n === 1'b1) begin
            unique case (gnt)
                2'b00: ok = !s_cyc && !s_stb && !m0_ack && !m1_ack && m0_rdat == '0 && m1_rdat == '0;
                2'b01: begin
`ifdef WB_ARB_TIMEOUT_EN
                    stb_ok = 1'b1;
`else
                    stb_ok = (s_stb == m_stb[0]);
`endif
                    ok = stb_ok && s_cyc == m_cyc[0] && s_we == m_we[0] && s_sel == m_sel[0] &&
                         s_addr == m_addr[0] && s_wdat == m_wdat[0] && m0_ack == s_ack &&
                         m0_rdat == s_rdat && !m1_ack && m1_rdat == '0;
                end
                2'b10: begin
`ifdef WB_ARB_TIMEOUT_EN
                    stb_ok = 1'b1;
`else
                    stb_ok = (s_stb == m_stb[1]);
`endif
                    ok = stb_ok && s_cyc == m_cyc[1] && s_we == m_we[1] && s_sel == m_sel[1] &&
                         s_addr == m_addr[1] && s_wdat == m_wdat[1] && m1_ack == s_ack &&
                         m1_rdat == s_rdat && !m0_ack && m0_rdat == '0;
                end
                default: ok = 1'b0;
            endcase
            if (!ok) $display("  routing detail: gnt=%b s_cyc=%b s_addr=%h m0_ack=%b m1_ack=%b", gnt, s_cyc, s_addr, m0_ack, m1_ack);
            check("routing", 64'(ok), 64'd1);

            if (m0_ack) begin
                if (q0.size() == 0) begin
                    check("m0_unexpected_ack", 64'(q0.size()), 64'd1);
                end else begin
                    e = q0.pop_front();
                    ack_cnt[0]++;
                    if (!e[32]) check("m0_rdata", 64'(m0_rdat), 64'(e[31:0]));
                end
            end
            if (m1_ack) begin
                if (q1.size() == 0) begin
                    check("m1_unexpected_ack", 64'(q1.size()), 64'd1);
                end else begin
                    e = q1.pop_front();
                    ack_cnt[1]++;
                    if (!e[32]) check("m1_rdata", 64'(m1_rdat), 64'(e[31:0]));
                end
            end

            if (burst_phase && m0_ack && m_cyc[1]) m0_ack_in_burst++;
            if (alt_phase && gnt != prev_gnt && gnt != 2'b00) begin
                if (last_new != 2'b00) check("alternate", 64'(gnt), 64'(~last_new & 2'b11));
                last_new = gnt;
                n_grants++;
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        logic [31:0] v;
        rst_n       = 1'b0;
        force_ack   = 1'b0;
        slave_stall = 1'b1;
        lat_max     = 0;
        lat         = 0;
        alt_phase   = 1'b0;
        burst_phase = 1'b0;
        n_grants    = 0;
        m0_ack_in_burst = 0;
        prev_gnt    = 2'b00;
        last_new    = 2'b00;
        for (int m = 0; m < 2; m++) begin
            issued[m] = 0; ack_cnt[m] = 0;
            m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = 1'b0;
            m_sel[m] = 4'hF; m_addr[m] = AW'(m * 64); m_wdat[m] = '0;
        end
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            slave_mem[i] = v;
            ref_mem[i]   = v;
        end
        slave_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]   = 32'hDEAD_BEEF;

        // Reset held with both masters requesting.
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            check("rst_gnt", 64'(gnt), 64'd0);
            check("rst_s_cyc", 64'(s_cyc), 64'd0);
            check("rst_acks", 64'({m0_ack, m1_ack}), 64'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); check("release_gnt_same_cycle", 64'(gnt), 64'd0);
        @(negedge clk); check("release_gnt_next", 64'(gnt), 64'b01);
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin m_cyc[m] = 1'b0; m_stb[m] = 1'b0; end
        gap(3);
        slave_stall = 1'b0;

        // Single M0 read: one arbitration cycle, then one slave cycle.
        issue(0, 1'b0, 4'hF, 32'h10, 32'h0);
        @(negedge clk); check("lat_idle_gnt", 64'(gnt), 64'd0);
        @(negedge clk); check("lat_gnt_m0", 64'(gnt), 64'b01);
        check("lat_s_addr", 64'(s_addr), 64'h10);
        @(negedge clk); check("m0_ack_timing", 64'(m0_ack), 64'd1);
        check("m0_read_data", 64'(m0_rdat), 64'hDEAD_BEEF);
        @(posedge clk); #1 m_cyc[0] = 1'b0; m_stb[0] = 1'b0;

        // Stray slave ack while idle.
        gap(2);
        force_ack = 1'b1;
        @(negedge clk); check("idle_ack_dropped", 64'({m0_ack, m1_ack}), 64'd0);
        check("idle_gnt", 64'(gnt), 64'd0);
        @(posedge clk); #1 force_ack = 1'b0;
        gap(1);

        // Both masters back-to-back: grants must alternate.
        alt_phase = 1'b1;
        fork
            begin repeat (4) begin master_burst(0, 1); gap(1); end end
            begin repeat (4) begin master_burst(1, 1); gap(1); end end
        join
        alt_phase = 1'b0;
        check("alt_grant_count", 64'(n_grants), 64'd8);
        gap(3);

        // M1 burst of 4 holds the grant against a pending M0.
        burst_phase = 1'b1;
        fork
            begin
                master_burst(1, 4);
                @(negedge clk); check("burst_drop_cycle_gnt", 64'(gnt), 64'b10);
                @(negedge clk); check("burst_handover_gnt", 64'(gnt), 64'b01);
            end
            begin
                wait_gnt(2'b10);
                @(posedge clk); #1;
                master_burst(0, 1);
            end
        join
        burst_phase = 1'b0;
        check("m0_acks_during_m1_burst", 64'(m0_ack_in_burst), 64'd0);
        gap(3);

        // Reset in the middle of an M1 transfer with the slave acking.
        slave_stall = 1'b1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = 32'h40;
        wait_gnt(2'b10);
        @(posedge clk); #1 rst_n = 1'b0; force_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_gnt", 64'(gnt), 64'd0);
        check("midrst_m1_ack", 64'(m1_ack), 64'd0);
        check("midrst_s_cyc", 64'(s_cyc), 64'd0);
        @(posedge clk); #1;
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; force_ack = 1'b0; rst_n = 1'b1;
        gap(2);
        slave_stall = 1'b0;

        // Randomized traffic with variable slave latency.
        lat_max = 2;
        fork
            begin repeat (30) begin master_burst(0, $urandom_range(4, 1)); gap($urandom_range(3, 1)); end end
            begin repeat (30) begin master_burst(1, $urandom_range(4, 1)); gap($urandom_range(3, 1)); end end
        join
        gap(5);

        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("m0_ack_total", 64'(ack_cnt[0]), 64'(issued[0]));
        check("m1_ack_total", 64'(ack_cnt[1]), 64'(issued[1]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
